// File: rtl/uart_pkg.sv
// Shared UART frame-format definitions, imported by both the receiver and transmitter cores.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;

  // Data bits per frame: 5 + sel, giving 5..8.
  function automatic logic [3:0] dbits(input logic [1:0] sel);
    return 4'd5 + {2'b00, sel};
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: frame-format selects in, received character and status out.
interface uart_rx_if;
  logic [2:0] dbit_select_i;
  logic [1:0] sbit_select_i;
  logic [1:0] parity_select_i;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       parity_error;
  logic       frame_error;
  logic       rx_busy;

  modport master (
    input  dbit_select_i, sbit_select_i, parity_select_i,
    output dout, rx_done_tick, parity_error, frame_error, rx_busy
  );

  modport slave (
    output dbit_select_i, sbit_select_i, parity_select_i,
    input  dout, rx_done_tick, parity_error, frame_error, rx_busy
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Line conditioning for the receiver: 2-FF synchronizer, plus a 3-tick majority voter
// when UART_RX_MAJORITY_EN is defined.
module uart_rx_sampler (
  input  logic clk,
  input  logic reset_n,
  input  logic s_tick,
  input  logic rx,
  output logic rx_s,
  output logic bit_s
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // Window is the two previous tick samples plus the current one, so the decision
  // lands on the same tick as the single-sample build and frame timing is unchanged.
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    hist_q <= 2'b11;
    else if (s_tick) hist_q <= {hist_q[0], rx_s};
  end

  assign bit_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  logic unused_tick;
  assign unused_tick = s_tick;
  assign bit_s       = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver core: 16x oversampled, runtime-selected 5-8 data bits, parity and stop length.
// Optional build macro UART_RX_MAJORITY_EN enables 3-tick majority sampling in uart_rx_sampler.
//
// state  | meaning
// IDLE   | waiting for line high (arm), then a low level starts a frame
// START  | counting to mid start bit; confirm low or drop as false start
// DATA   | sampling data bits LSB first at each bit mid
// PARITY | sampling and checking the parity bit
// STOP   | sampling stop bit, then strobing the character out
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      s_tick,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int CW = $clog2(2 * OVERSAMPLE);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] MID_START = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_END   = CW'(OVERSAMPLE - 1);

  logic            rx_s;
  logic            bit_s;
  rx_state_e       state;
  logic            armed;
  logic [CW-1:0]   s_cnt;
  logic [2:0]      n_cnt;
  logic [7:0]      shreg;
  logic [1:0]      cfg_dbit;
  logic [1:0]      cfg_sbit;
  logic [1:0]      cfg_par;
  logic            par_err_r;
  logic            frm_err_r;
  logic [7:0]      dout_q;
  logic            done_q;
  logic            par_err_q;
  logic            frm_err_q;
  logic            busy_q;

  logic [3:0]      nbits;
  logic [2:0]      n_last;
  logic            par_en;
  logic            par_exp;
  logic [CW-1:0]   stop_last;
  logic            frm_now;
  logic            unused_dbit_msb;

  uart_rx_sampler u_sampler (
    .clk     (clk),
    .reset_n (reset_n),
    .s_tick  (s_tick),
    .rx      (rx),
    .rx_s    (rx_s),
    .bit_s   (bit_s)
  );

  assign unused_dbit_msb = bus.dbit_select_i[2];

  assign nbits   = dbits(cfg_dbit);
  assign n_last  = 3'(nbits - 4'd1);
  assign par_en  = (cfg_par == PAR_EVEN) || (cfg_par == PAR_ODD);
  assign par_exp = (cfg_par == PAR_ODD) ? ~(^shreg) : (^shreg);

  always_comb begin
    stop_last = BIT_END;
    case (cfg_sbit)
      STOP_1P5: stop_last = CW'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
      STOP_2:   stop_last = CW'(2 * OVERSAMPLE - 1);
      default:  stop_last = BIT_END;
    endcase
  end

  // With a one-bit stop the sample and the end of frame fall on the same tick.
  always_comb begin
    frm_now = frm_err_r;
    if (s_cnt == BIT_END) frm_now = ~bit_s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      armed     <= 1'b0;
      s_cnt     <= '0;
      n_cnt     <= '0;
      shreg     <= '0;
      cfg_dbit  <= '0;
      cfg_sbit  <= STOP_1;
      cfg_par   <= PAR_NONE;
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            s_cnt     <= '0;
            shreg     <= '0;
            par_err_r <= 1'b0;
            frm_err_r <= 1'b0;
            cfg_dbit  <= bus.dbit_select_i[1:0];
            cfg_sbit  <= bus.sbit_select_i;
            cfg_par   <= bus.parity_select_i;
            busy_q    <= 1'b1;
            state     <= ST_START;
          end
        end

        ST_START: begin
          if (s_tick) begin
            if (s_cnt == MID_START) begin
              if (!bit_s) begin
                s_cnt <= '0;
                n_cnt <= '0;
                state <= ST_DATA;
              end else begin
                armed  <= 1'b0;
                busy_q <= 1'b0;
                state  <= ST_IDLE;
              end
            end else begin
              s_cnt <= s_cnt + ONE;
            end
          end
        end

        ST_DATA: begin
          if (s_tick) begin
            if (s_cnt == BIT_END) begin
              s_cnt <= '0;
              shreg <= {bit_s, shreg[7:1]};
              if (n_cnt == n_last) state <= par_en ? ST_PARITY : ST_STOP;
              else                 n_cnt <= n_cnt + 3'd1;
            end else begin
              s_cnt <= s_cnt + ONE;
            end
          end
        end

        ST_PARITY: begin
          if (s_tick) begin
            if (s_cnt == BIT_END) begin
              s_cnt     <= '0;
              par_err_r <= (bit_s != par_exp);
              state     <= ST_STOP;
            end else begin
              s_cnt <= s_cnt + ONE;
            end
          end
        end

        ST_STOP: begin
          if (s_tick) begin
            if (s_cnt == BIT_END) frm_err_r <= ~bit_s;
            if (s_cnt == stop_last) begin
              dout_q    <= shreg >> (4'd8 - nbits);
              par_err_q <= par_err_r;
              frm_err_q <= frm_now;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              armed     <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              s_cnt <= s_cnt + ONE;
            end
          end
        end

        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.parity_error = par_err_q;
  assign bus.frame_error  = frm_err_q;
  assign bus.rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scoreboard of expected characters, popped on each done strobe.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int OS = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic s_tick  = 1'b0;
  logic rx      = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_tick  (s_tick),
    .rx      (rx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tick_div = 10;
  int tick_cnt = 0;

  always @(negedge clk) begin
    if (tick_cnt >= tick_div - 1) begin
      tick_cnt = 0;
      s_tick   = 1'b1;
    end else begin
      tick_cnt = tick_cnt + 1;
      s_tick   = 1'b0;
    end
  end

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   total       = 0;
  int   bad         = 0;
  int   strobes     = 0;
  int   exp_strobes = 0;
  int   busy_clks   = 0;
  logic done_prev   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.rx_busy) busy_clks++;
      if (bus.rx_done_tick) begin
        exp_t e;
        strobes++;
        chk("done_width", 32'(done_prev), 32'd0);
        chk("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("dout", 32'(bus.dout), 32'(e.d));
          chk("parity_error", 32'(bus.parity_error), 32'(e.pe));
          chk("frame_error", 32'(bus.frame_error), 32'(e.fe));
        end
      end
    end
    done_prev = bus.rx_done_tick;
  end

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    exp_q.push_back(e);
    exp_strobes++;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic set_fmt(input logic [2:0] dsel, input logic [1:0] ssel, input logic [1:0] psel);
    bus.dbit_select_i   = dsel;
    bus.sbit_select_i   = ssel;
    bus.parity_select_i = psel;
  endtask

  // pmode: 0 none, 1 even, 2 odd; pflip inverts the parity bit actually sent.
  task automatic send_frame(input logic [7:0] d, input int nb, input int pmode, input logic pflip,
                            input int stop_ticks, input logic stop_val);
    logic [7:0] m;
    logic       p;
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      wait_ticks(OS);
    end
    if (pmode != 0) begin
      m  = 8'hFF >> (8 - nb);
      p  = (^(d & m)) ^ (pmode == 2) ^ pflip;
      rx = p;
      wait_ticks(OS);
    end
    rx = stop_val;
    wait_ticks(stop_ticks);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"}, 32'(bus.dout), 32'd0);
    chk({tag, "_done"}, 32'(bus.rx_done_tick), 32'd0);
    chk({tag, "_perr"}, 32'(bus.parity_error), 32'd0);
    chk({tag, "_ferr"}, 32'(bus.frame_error), 32'd0);
    chk({tag, "_busy"}, 32'(bus.rx_busy), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    set_fmt(3'b011, STOP_1, PAR_EVEN);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    wait_ticks(4);

    // 8-E-1 0x41, tick every 10 clk
    busy_clks = 0;
    push_exp(8'h41, 1'b0, 1'b0);
    send_frame(8'h41, 8, 1, 1'b0, OS, 1'b1);
    wait_drain("drain_8e1");
    chk("busy_len_8e1", 32'(busy_clks >= 1600 && busy_clks <= 1760), 32'd1);
    chk("busy_idle_8e1", 32'(bus.rx_busy), 32'd0);

    tick_div = 4;
    wait_ticks(4);

    // 8-O-1 0x55 carrying an even parity bit
    set_fmt(3'b011, STOP_1, PAR_ODD);
    push_exp(8'h55, 1'b1, 1'b0);
    send_frame(8'h55, 8, 2, 1'b1, OS, 1'b1);
    wait_drain("drain_8o1");

    // 7-E-2 0x66 then 0x7F back to back; bit 2 of dbit select must be ignored
    set_fmt(3'b110, STOP_2, PAR_EVEN);
    push_exp(8'h66, 1'b0, 1'b0);
    push_exp(8'h7F, 1'b0, 1'b0);
    send_frame(8'h66, 7, 1, 1'b0, 2 * OS, 1'b1);
    send_frame(8'h7F, 7, 1, 1'b0, 2 * OS, 1'b1);
    wait_drain("drain_7e2");

    // 8-N-1 0x99 with low stop, then break
    set_fmt(3'b011, STOP_1, PAR_NONE);
    s0 = strobes;
    push_exp(8'h99, 1'b0, 1'b1);
    send_frame(8'h99, 8, 0, 1'b0, OS, 1'b0);
    wait_ticks(4 * OS);
    chk("break_strobes_low", 32'(strobes - s0), 32'd1);
    rx = 1'b1;
    wait_ticks(2 * OS);
    chk("break_strobes_high", 32'(strobes - s0), 32'd1);
    chk("break_busy", 32'(bus.rx_busy), 32'd0);

    // 4-tick low pulse: false start
    s0 = strobes;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(2);
    chk("false_start_busy_hi", 32'(bus.rx_busy), 32'd1);
    wait_ticks(20);
    chk("false_start_busy_lo", 32'(bus.rx_busy), 32'd0);
    chk("false_start_strobes", 32'(strobes - s0), 32'd0);

`ifdef UART_RX_MAJORITY_EN
    // 1-tick glitch at the middle of data bit 3 of 0x00
    push_exp(8'h00, 1'b0, 1'b0);
    rx = 1'b0;
    wait_ticks(OS);
    wait_ticks(3 * OS);
    wait_ticks(OS / 2 - 1);
    rx = 1'b1;
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(OS / 2);
    wait_ticks(4 * OS);
    rx = 1'b1;
    wait_ticks(OS);
    wait_drain("drain_glitch");
`endif

    // reset during data bit 4, then a clean 0xA5
    begin
      logic [7:0] d;
      d  = 8'hA5;
      rx = 1'b0;
      wait_ticks(OS);
      for (int i = 0; i < 4; i++) begin
        rx = d[i];
        wait_ticks(OS);
      end
      rx = d[4];
      wait_ticks(OS / 2);
      chk("pre_reset_busy", 32'(bus.rx_busy), 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midreset");
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      wait_ticks(20);
      push_exp(8'hA5, 1'b0, 1'b0);
      send_frame(8'hA5, 8, 0, 1'b0, OS, 1'b1);
      wait_drain("drain_after_reset");
    end

    wait_ticks(8);
    chk("strobe_total", 32'(strobes), 32'(exp_strobes));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
